// File: rtl/rs_pkg.sv
// Shared types for the reservation-station issue queue.
package rs_pkg;

  localparam int unsigned RS_N     = 8;
  localparam int unsigned RS_OP_W  = 16;
  localparam int unsigned RS_TAG_W = 6;

  typedef struct packed {
    logic                valid;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] src1_tag;
    logic                src1_rdy;
    logic [RS_TAG_W-1:0] src2_tag;
    logic                src2_rdy;
    logic [RS_TAG_W-1:0] dst_tag;
  } rs_entry_t;

endpackage

// File: rtl/priority_encoder.sv
// Highest-set-index priority encoder; idx is 0 when no bit is set.
module priority_encoder #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: holds micro-ops until both sources are
// ready, snoops the CDB for wakeups and issues one ready entry per cycle.
module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int unsigned N     = RS_N,
  parameter int unsigned OP_W  = RS_OP_W,
  parameter int unsigned TAG_W = RS_TAG_W,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic             disp_src1_rdy,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src2_rdy,
  input  logic [TAG_W-1:0] disp_dst_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [OP_W-1:0]  iss_op,
  output logic [TAG_W-1:0] iss_src1_tag,
  output logic [TAG_W-1:0] iss_src2_tag,
  output logic [TAG_W-1:0] iss_dst_tag,
  output logic [IDX_W-1:0] iss_idx,
  output logic [IDX_W:0]   occupancy,
  output logic             empty,
  output logic             full
);

  rs_entry_t [N-1:0] ent_q, ent_d;
  logic [IDX_W:0]    occ_q, occ_d;

  logic [N-1:0]      req, free;
  logic [IDX_W-1:0]  sel_idx, alloc_idx;
  logic              sel_any, alloc_any;
  logic              disp_fire, iss_fire;

  always_comb begin
    req  = '0;
    free = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req[i]  = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
      free[i] = ~ent_q[i].valid;
    end
  end

  priority_encoder #(.N(N), .IDX_W(IDX_W)) u_sel (
    .req_i   (req),
    .idx_o   (sel_idx),
    .valid_o (sel_any)
  );

  priority_encoder #(.N(N), .IDX_W(IDX_W)) u_alloc (
    .req_i   (free),
    .idx_o   (alloc_idx),
    .valid_o (alloc_any)
  );

  // Status comes from registered occupancy only, so an issue this cycle
  // cannot open a slot for a dispatch in the same cycle.
  assign full       = (occ_q == (IDX_W+1)'(N));
  assign empty      = (occ_q == '0);
  assign occupancy  = occ_q;
  assign disp_ready = ~full;

  assign iss_valid    = sel_any & ~flush;
  assign iss_op       = ent_q[sel_idx].op;
  assign iss_src1_tag = ent_q[sel_idx].src1_tag;
  assign iss_src2_tag = ent_q[sel_idx].src2_tag;
  assign iss_dst_tag  = ent_q[sel_idx].dst_tag;
  assign iss_idx      = sel_idx;

  assign disp_fire = disp_valid & disp_ready & alloc_any & ~flush;
  assign iss_fire  = iss_valid & iss_ready;

  always_comb begin
    ent_d = ent_q;
    occ_d = occ_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (cdb_valid && ent_q[i].valid) begin
        if (ent_q[i].src1_tag == cdb_tag) ent_d[i].src1_rdy = 1'b1;
        if (ent_q[i].src2_tag == cdb_tag) ent_d[i].src2_rdy = 1'b1;
      end
    end
    if (iss_fire) begin
      ent_d[sel_idx].valid = 1'b0;
    end
    // The allocated slot is free, so it never collides with the issuing one.
    if (disp_fire) begin
      ent_d[alloc_idx].valid    = 1'b1;
      ent_d[alloc_idx].op       = disp_op;
      ent_d[alloc_idx].src1_tag = disp_src1_tag;
      ent_d[alloc_idx].src1_rdy = disp_src1_rdy | (cdb_valid & (cdb_tag == disp_src1_tag));
      ent_d[alloc_idx].src2_tag = disp_src2_tag;
      ent_d[alloc_idx].src2_rdy = disp_src2_rdy | (cdb_valid & (cdb_tag == disp_src2_tag));
      ent_d[alloc_idx].dst_tag  = disp_dst_tag;
    end
    occ_d = occ_q + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(iss_fire);
    if (flush) begin
      for (int unsigned i = 0; i < N; i++) ent_d[i].valid = 1'b0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      occ_q <= '0;
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Reservation-station issue queue for the OoO execution cluster.
- Holds dispatched micro-ops until both source operands are ready.
- Snoops the common data bus (CDB) for wakeups.
- Selects one ready entry per cycle for the functional unit.
- Builds the per-entry ready and free vectors and feeds them to priority_encoder instances for select and allocate.

Parameters:
- N, 8: number of entries; power of 2, at least 2.
- OP_W, 16: opaque micro-op payload width.
- TAG_W, 6: physical register tag width.
- IDX_W, $clog2(N): entry index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch.
- disp_op  in  OP_W  micro-op payload.
- disp_src1_tag  in  TAG_W  source 1 tag.
- disp_src1_rdy  in  1  source 1 already available.
- disp_src2_tag  in  TAG_W  source 2 tag.
- disp_src2_rdy  in  1  source 2 already available.
- disp_dst_tag  in  TAG_W  destination tag.
- cdb_valid  in  1  wakeup broadcast valid.
- cdb_tag  in  TAG_W  tag being produced.
- iss_valid  out  1  a ready entry is presented.
- iss_ready  in  1  functional unit accepts the issue.
- iss_op  out  OP_W  payload of the selected entry.
- iss_src1_tag  out  TAG_W  source 1 tag of the selected entry.
- iss_src2_tag  out  TAG_W  source 2 tag of the selected entry.
- iss_dst_tag  out  TAG_W  destination tag of the selected entry.
- iss_idx  out  IDX_W  index of the selected entry.
- occupancy  out  IDX_W+1  number of valid entries.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == N.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all entry valid and ready bits cleared.
  - occupancy = 0, empty = 1, full = 0.
  - disp_ready = 1, iss_valid = 0; all iss_* data outputs = 0.
- Entry state: valid, op, src1/src2 tag, src1/src2 rdy, dst tag.
- Allocation:
  - disp_ready = !full, computed from registered state.
  - An issue in the same cycle does not free a slot for a dispatch in that cycle.
  - On disp_valid && disp_ready && !flush, the highest-index free entry is written at the next edge (priority_encoder over ~valid).
- Dispatch/wakeup bypass: if cdb_valid and cdb_tag equals disp_srcX_tag in the dispatch cycle, that source is stored ready.
- Wakeup:
  - Each cycle, every valid entry whose srcX_tag == cdb_tag with cdb_valid high sets srcX_rdy at the edge.
  - Matching is on tag only; several entries may wake at once.
- Select:
  - Combinational; req[i] = valid & src1_rdy & src2_rdy.
  - The highest set index wins (priority_encoder).
  - iss_valid = |req && !flush; iss_* driven from the winning entry.
  - When iss_valid = 0, the iss_* data outputs are don't-care.
- Issue: on iss_valid && iss_ready, the winning entry's valid bit is cleared at the edge.
- Latency:
  - An entry dispatched at edge t can issue in cycle t+1 at the earliest.
  - A CDB wakeup in cycle t makes the entry issuable in cycle t+1; there is no same-cycle wakeup-to-issue.
- iss_valid may drop without handshake only on flush. Otherwise, with iss_ready low, the selected entry stays presented. The selection may change if a higher-index entry becomes ready.
- occupancy: next = occ + dispatch_fire - issue_fire; a simultaneous dispatch and issue leaves it unchanged.
- flush:
  - Clears all valid bits at the edge.
  - Overrides dispatch and issue fire in the same cycle.
  - occupancy becomes 0.
- Reset asserted mid-operation discards all entries immediately. Outputs take reset values asynchronously.

Decomposition:
- Package rs_pkg: rs_entry_t struct (valid, op, src1_tag, src1_rdy, src2_tag, src2_rdy, dst_tag); default widths as localparams.
- Sub-module: two priority_encoder instances (N bits). The select instance runs over req; the allocate instance runs over ~valid. Entry storage and wakeup compare stay in this module.

Test Plan:
- Reset, then dispatch op=0x1234, src1_rdy=1, src2_rdy=1, dst=5 -> next cycle iss_valid=1, iss_idx=7, iss_dst_tag=5, occupancy=1; with iss_ready=1, occupancy=0 and empty=1 after the edge.
- Dispatch with src1_tag=3 not ready, src2 ready; hold 3 cycles -> iss_valid=0. Drive cdb_valid=1, cdb_tag=3 -> iss_valid=1 exactly one cycle later.
- Dispatch with src1_tag=9 not ready while cdb_valid=1, cdb_tag=9 in the same cycle -> entry issuable next cycle (bypass).
- Fill 8 entries with iss_ready=0 -> full=1, disp_ready=0, occupancy=8. A further disp_valid is not accepted. Issue one -> disp_ready=1 the following cycle.
- Three entries ready at idx 7, 6, 5 with iss_ready=1 -> issues idx 7, 6, 5 on consecutive cycles. A simultaneous dispatch plus issue keeps occupancy constant.
- 4 entries valid; assert flush together with disp_valid and iss_ready -> iss_valid=0 that cycle; occupancy=0, empty=1 next cycle; nothing issued.
